// File: rtl/everloop_frame_buffer.sv
// ---------------------------------------------------------------------------
// everloop_frame_buffer
//
// Double-buffered (ping-pong) frame store for the everloop LED ring.
// The CPU writer fills the back bank, the LED serialiser reads the front
// bank, and a swap request flips the banks only between serialiser frames.
// A hardware clear zero-fills the back bank one word per cycle.
//
// Ports:
//   i_clk          clock, all logic on rising edge
//   i_rst_n        synchronous active-low reset
//   i_d_in         write data
//   i_addr_wr      write address into the back bank
//   i_wr           write strobe
//   i_addr_rd      read address into the front bank
//   i_rd           read strobe
//   o_d_out        registered read data (latency 1, holds when no read)
//   o_rd_valid     one-cycle pulse: o_d_out updated by a read
//   i_swap_req     request a bank swap (pulse)
//   i_frame_busy   serialiser mid-frame, swap must wait
//   o_swap_pending swap requested, not yet executed
//   o_bank_sel     current front bank index
//   i_clear        request a zero-fill of the back bank (pulse)
//   o_clear_busy   clear in progress
//   o_err          one-cycle pulse: previous-cycle request rejected
//   o_fsm_state    debug view of the FSM state (0 = IDLE, 1 = CLEAR)
//
// Handshake: strobes (i_wr, i_rd, i_swap_req, i_clear) are sampled on every
// rising edge with no back-pressure; acceptance or rejection is reported one
// cycle later through o_rd_valid / o_err, never by stalling the requester.
// ---------------------------------------------------------------------------
module everloop_frame_buffer #(
    parameter int DATA_W   = 8,
    parameter int LEDS     = 35,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_d_in,
    input  logic [ADDR_W-1:0] i_addr_wr,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr_rd,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_d_out,
    output logic              o_rd_valid,
    input  logic              i_swap_req,
    input  logic              i_frame_busy,
    output logic              o_swap_pending,
    output logic              o_bank_sel,
    input  logic              i_clear,
    output logic              o_clear_busy,
    output logic              o_err,
    output logic              o_fsm_state
);

    localparam int DEPTH = LEDS * CHANNELS;
    localparam int IDX_W = $clog2(2 * DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    logic              r_bank_sel;
    logic              r_swap_pending;
    logic [DATA_W-1:0] r_d_out;
    logic              r_rd_valid;
    logic              r_err;

    // Both banks in one array so synthesis can map it onto a single RAM:
    // bank b, address a lives at index b*DEPTH + a.
    logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];

    logic              w_idle;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_swap_exec;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [IDX_W-1:0]  w_widx;
    logic [IDX_W-1:0]  w_ridx;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_wr_in_range = (i_addr_wr <= LAST_ADDR);
    assign w_rd_in_range = (i_addr_rd <= LAST_ADDR);

    // Swaps wait for the serialiser frame gap and for any clear to finish,
    // so a clear always targets a single bank from start to end.
    assign w_swap_exec   = r_swap_pending & ~i_frame_busy & w_idle;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, clear counter and write-port mux
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_we          = 1'b0;
        w_waddr       = i_addr_wr;
        w_wdata       = i_d_in;
        case (r_state)
            ST_IDLE: begin
                // A write in the same cycle as a clear request is still
                // accepted; the clear then overwrites it.
                if (i_wr && w_wr_in_range) begin
                    w_we = 1'b1;
                end
                if (i_clear) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_cnt;
                w_wdata = '0;
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Writes always land in the back bank, reads always come from the front.
    assign w_widx = IDX_W'(w_waddr) + (r_bank_sel ? IDX_W'(0) : IDX_W'(DEPTH));
    assign w_ridx = IDX_W'(i_addr_rd) + (r_bank_sel ? IDX_W'(DEPTH) : IDX_W'(0));

    // ------------------------------------------------------------------
    // Storage (no reset so it stays inferable as block RAM)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read port, error flag, bank selection
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_d_out        <= '0;
            r_rd_valid     <= 1'b0;
            r_err          <= 1'b0;
            r_bank_sel     <= 1'b0;
            r_swap_pending <= 1'b0;
        end else begin
            r_rd_valid <= i_rd;
            // r_bank_sel is still the pre-swap value here, so a read in the
            // swap cycle returns old-front data.
            if (i_rd) begin
                if (w_rd_in_range) begin
                    r_d_out <= r_mem[w_ridx];
                end else begin
                    r_d_out <= '0;
                end
            end
            r_err <= (i_wr && (!w_wr_in_range || !w_idle)) ||
                     (i_rd && !w_rd_in_range);
            if (w_swap_exec) begin
                r_bank_sel <= ~r_bank_sel;
            end
            // A request arriving in the execute cycle re-arms pending, so a
            // second swap follows.
            r_swap_pending <= i_swap_req | (r_swap_pending & ~w_swap_exec);
        end
    end

    assign o_d_out        = r_d_out;
    assign o_rd_valid     = r_rd_valid;
    assign o_err          = r_err;
    assign o_bank_sel     = r_bank_sel;
    assign o_swap_pending = r_swap_pending;
    assign o_clear_busy   = (r_state == ST_CLEAR);
    assign o_fsm_state    = r_state;

endmodule

// File: tb/tb_everloop_frame_buffer.sv
module tb_everloop_frame_buffer;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 140;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [DW-1:0] d_in = '0;
  logic [AW-1:0] addr_wr = '0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr_rd = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] d_out;
  logic          rd_valid;
  logic          swap_req = 1'b0;
  logic          frame_busy = 1'b0;
  logic          swap_pending;
  logic          bank_sel;
  logic          clear = 1'b0;
  logic          clear_busy;
  logic          err;
  logic          fsm_state;

  everloop_frame_buffer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_d_in         (d_in),
    .i_addr_wr      (addr_wr),
    .i_wr           (wr),
    .i_addr_rd      (addr_rd),
    .i_rd           (rd),
    .o_d_out        (d_out),
    .o_rd_valid     (rd_valid),
    .i_swap_req     (swap_req),
    .i_frame_busy   (frame_busy),
    .o_swap_pending (swap_pending),
    .o_bank_sel     (bank_sel),
    .i_clear        (clear),
    .o_clear_busy   (clear_busy),
    .o_err          (err),
    .o_fsm_state    (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame store as two plain arrays, plus a "known" bit because RAM is not
  // reset. A clear is a count of words still to zero.
  logic [DW-1:0] m_mem   [2][DEPTH];
  bit            m_known [2][DEPTH];
  logic [DW-1:0] m_dout;
  bit            m_dout_known;
  bit            m_valid, m_err, m_bank, m_pend;
  int            m_clr_left;
  bit            m_started = 0;
  logic [DW:0]   exp_q[$];   // {known, data} for each read result

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_known[b][a] = 0;
  end

  always @(posedge clk) begin
    bit idle, do_swap;
    m_started = 1;
    if (!rst_n) begin
      m_dout = '0; m_dout_known = 1; m_valid = 0; m_err = 0;
      m_bank = 0; m_pend = 0; m_clr_left = 0;
    end else begin
      idle = (m_clr_left == 0);
      m_valid = rd;
      if (rd) begin
        if (int'(addr_rd) < DEPTH) begin
          m_dout       = m_mem[m_bank][addr_rd];
          m_dout_known = m_known[m_bank][addr_rd];
        end else begin
          m_dout = '0; m_dout_known = 1;
        end
        exp_q.push_back({m_dout_known, m_dout});
      end
      m_err = (wr && (int'(addr_wr) >= DEPTH || !idle)) || (rd && int'(addr_rd) >= DEPTH);
      if (wr && idle && int'(addr_wr) < DEPTH) begin
        m_mem[!m_bank][addr_wr]   = d_in;
        m_known[!m_bank][addr_wr] = 1;
      end
      if (!idle) begin
        m_mem[!m_bank][DEPTH - m_clr_left]   = '0;
        m_known[!m_bank][DEPTH - m_clr_left] = 1;
        m_clr_left--;
      end else if (clear) begin
        m_clr_left = DEPTH;
      end
      do_swap = m_pend && !frame_busy && idle;
      m_pend  = swap_req || (m_pend && !do_swap);
      if (do_swap) m_bank = !m_bank;
    end
  end

  // one compare process, every cycle
  always @(negedge clk) begin
    logic [DW:0] e;
    if (m_started) begin
      check("rd_valid", rd_valid, m_valid);
      check("err", err, m_err);
      check("bank_sel", bank_sel, m_bank);
      check("swap_pending", swap_pending, m_pend);
      check("clear_busy", clear_busy, m_clr_left != 0);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("read_queue_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e[DW]) check("d_out_read", d_out, e[DW-1:0]);
        end
      end else if (m_dout_known) begin
        check("d_out_hold", d_out, m_dout);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input int a, input int d);
    wr = 1; addr_wr = AW'(a); d_in = DW'(d);
    tick();
    wr = 0;
  endtask

  task automatic do_read(input int a);
    rd = 1; addr_rd = AW'(a);
    tick();
    rd = 0;
  endtask

  task automatic pulse_swap();
    swap_req = 1; tick(); swap_req = 0;
  endtask

  task automatic pulse_clear();
    clear = 1; tick(); clear = 0;
  endtask

  task automatic wait_clear_done(output int n);
    n = 0;
    while (clear_busy && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check("clear_timeout", 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) tick();
    check("reset_bank_sel", bank_sel, 0);
    check("reset_d_out", d_out, 0);
    check("reset_clear_busy", clear_busy, 0);
    rst_n = 1;
    tick();

    // bring both banks to a known all-zero state
    pulse_clear(); wait_clear_done(n);
    pulse_swap(); tick();
    pulse_clear(); wait_clear_done(n);
    pulse_swap(); tick();
    check("init_bank_sel", bank_sel, 0);

    // reset-then-read, then immediate swap
    do_write(3, 8'hA5);
    do_read(3);
    check("pre_swap_read", d_out, 8'h00);
    pulse_swap();
    check("swap_pending_set", swap_pending, 1);
    check("swap_not_yet", bank_sel, 0);
    tick();
    check("swap_done", bank_sel, 1);
    do_read(3);
    check("post_swap_read", d_out, 8'hA5);
    check("post_swap_valid", rd_valid, 1);

    // deferred swap
    frame_busy = 1;
    pulse_swap();
    repeat (20) tick();
    check("deferred_bank", bank_sel, 1);
    check("deferred_pending", swap_pending, 1);
    frame_busy = 0;
    tick();
    check("deferred_swapped", bank_sel, 0);
    check("deferred_pending_clr", swap_pending, 0);

    // clear of a full back bank
    for (int a = 0; a < DEPTH; a++) do_write(a, 8'hFF);
    pulse_clear();
    wait_clear_done(n);
    check("clear_len", n, DEPTH);
    pulse_swap(); tick();
    check("clear_swap", bank_sel, 1);
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a);
      check("cleared_word", d_out, 0);
    end

    // bounds: back is bank 0, addr 140 must not alias into bank 1
    do_write(140, 8'h33);
    check("oob_wr_err", err, 1);
    do_read(0);
    check("oob_wr_no_alias", d_out, 0);
    do_read(200);
    check("oob_rd_data", d_out, 0);
    check("oob_rd_valid", rd_valid, 1);
    check("oob_rd_err", err, 1);

    // clear interplay
    pulse_clear();
    do_write(5, 8'h77);
    check("wr_in_clear_err", err, 1);
    pulse_swap();
    wait_clear_done(n);
    check("swap_deferred_clear", bank_sel, 1);
    check("swap_pending_clear", swap_pending, 1);
    tick();
    check("swap_after_clear", bank_sel, 0);
    do_read(5);
    check("wr_in_clear_dropped", d_out, 0);

    // reset in the middle of a clear
    pulse_clear();
    repeat (49) tick();
    check("mid_clear_busy", clear_busy, 1);
    rst_n = 0; tick(); rst_n = 1;
    check("rst_clear_busy", clear_busy, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_pending", swap_pending, 0);
    check("rst_d_out", d_out, 0);
    do_write(7, 8'h5A);
    pulse_swap(); tick();
    do_read(7);
    check("after_rst_read", d_out, 8'h5A);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      wr       = ($urandom_range(0, 3) == 0);
      addr_wr  = AW'($urandom_range(0, 150));
      d_in     = DW'($urandom);
      rd       = ($urandom_range(0, 1) == 0);
      addr_rd  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(140, 255))
                                            : AW'($urandom_range(0, DEPTH - 1));
      swap_req = ($urandom_range(0, 30) == 0);
      clear    = ($urandom_range(0, 300) == 0);
      if ($urandom_range(0, 15) == 0) frame_busy = ~frame_busy;
      rst_n    = ($urandom_range(0, 1500) != 0);
      tick();
    end
    wr = 0; rd = 0; swap_req = 0; clear = 0; rst_n = 1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
